cache_line_fill_ctrl: RTL and testbench
=======================================

// Module: cache_line_fill_ctrl
// PURPOSE
//   Miss handler that sits directly downstream of the direct-mapped 4-column data cache.
//   On a miss it optionally writes the dirty victim line back to burst memory (PSRAM
//   controller), then reads the missing 4-word line and streams it into the cache write port.
//   It drives the cache write port one word per cycle, so the cache sets the tag valid and
//   the line becomes a hit.
// PARAMETERS
//   LINE_IX_BITWIDTH  8   cache line index width; must match the cache instance
//   TAG_BITWIDTH      derived localparam = 32 - LINE_IX_BITWIDTH - 4 (not overridable)
// PORTS
//   clk                in   1    system clock, all state on rising edge
//   rst_n              in   1    asynchronous active-low reset
//   req_valid          in   1    miss request
//   req_ready          out  1    high only in IDLE; request accepted when valid&&ready
//   req_address        in   32   address of missing word (byte address)
//   req_evict          in   1    victim line valid and dirty -> write back first
//   req_evict_tag      in   TAG  victim tag
//   req_evict_line     in   128  victim data, [31:0]=word0 .. [127:96]=word3
//   mem_cmd_valid      out  1    burst command request
//   mem_cmd_ready      in   1    burst command accepted
//   mem_cmd_write      out  1    1=write burst, 0=read burst (4 words)
//   mem_cmd_address    out  32   line-aligned burst address (bits[3:0]=0)
//   mem_wr_data        out  32   write-burst word
//   mem_wr_data_ready  in   1    memory consumes mem_wr_data this cycle
//   mem_rd_data        in   32   read-burst word
//   mem_rd_data_valid  in   1    mem_rd_data valid this cycle
//   fill_address       out  32   cache write address (line base + 4*word)
//   fill_data          out  32   cache write data
//   fill_write_enable  out  1    cache write strobe
//   done               out  1    one-cycle pulse: line filled
// BEHAVIOUR
//   - Reset: state=IDLE, counter=0, req_ready=1 after release; every other output = 0.
//   - States: IDLE, WB_CMD, WB_DATA, RD_CMD, RD_DATA, DONE. 2-bit word counter.
//   - IDLE: on req_valid&&req_ready, register address, evict flag, tag and line;
//     next = req_evict ? WB_CMD : RD_CMD. req_valid while busy is ignored.
//   - Line base = {req_address[31:4],4'h0}; writeback address =
//     {req_evict_tag, req_address[LINE_IX_BITWIDTH+3:4], 4'h0}.
//   - WB_CMD: mem_cmd_valid=1, write=1, address=writeback address; fields held stable
//     until mem_cmd_ready. On accept -> WB_DATA, counter=0.
//   - WB_DATA: mem_wr_data = victim word[counter]; each cycle with mem_wr_data_ready,
//     counter++. After word 3 is consumed -> RD_CMD. Data phase starts no earlier than
//     the cycle after command accept.
//   - RD_CMD: mem_cmd_valid=1, write=0, address=line base; on accept -> RD_DATA,
//     counter=0.
//   - RD_DATA: each mem_rd_data_valid cycle registers fill_data=mem_rd_data,
//     fill_address=base+4*counter, fill_write_enable=1 on the next cycle (1-cycle
//     latency), then counter++. After word 3 -> DONE. Words are filled in order 0..3.
//   - DONE: done=1 for one cycle (same cycle as the word-3 fill strobe), then IDLE.
//   - mem_rd_data_valid outside RD_DATA and mem_wr_data_ready outside WB_DATA are ignored.
//   - The counter wraps 3->0 only on the state transition; no partial-line completion.
//   - Back-pressure: any number of stall cycles between words is legal; outputs hold.
//   - Reset mid-operation: immediate return to IDLE with outputs cleared.
//     No further fill writes occur and the line stays invalid. The memory controller
//     shares rst_n, so the abandoned burst is not resumed.
// TESTING
//   1 Clean miss: req addr=0x0000_1234, evict=0; mem answers 0xA0..0xA3 -> read cmd
//     addr 0x1230, fills 0x1230..0x123C with 0xA0..0xA3, done pulses once.
//   2 Dirty miss: evict=1, tag=0x00001, line ix=0x23, line={D3,D2,D1,D0} -> write cmd
//     addr 0x0000_1230 with D0..D3, then read cmd, then 4 fills, done.
//   3 Stalls: mem_cmd_ready low 5 cycles, wr_data_ready toggling, gaps in rd_valid ->
//     cmd fields stable, no word lost or duplicated, fill count = 4.
//   4 Spurious rd_data_valid in IDLE/WB_DATA -> no fill_write_enable asserted.
//   5 rst_n low after 2nd fill word -> outputs 0 asynchronously, IDLE, req_ready=1 post
//     release; a new request completes normally.
//   6 req_valid held high through busy -> exactly one request accepted per IDLE visit.

Source files
------------

// File: rtl/cache_line_fill_ctrl.sv
// Miss handler for the direct-mapped data cache: optionally writes the dirty victim line
// back to burst memory, then reads the missing 4-word line and streams it into the cache.
module cache_line_fill_ctrl #(
  parameter  int LINE_IX_BITWIDTH = 8,
  localparam int TAG_BITWIDTH     = 32 - LINE_IX_BITWIDTH - 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [31:0]             req_address,
  input  logic                    req_evict,
  input  logic [TAG_BITWIDTH-1:0] req_evict_tag,
  input  logic [127:0]            req_evict_line,
  output logic                    mem_cmd_valid,
  input  logic                    mem_cmd_ready,
  output logic                    mem_cmd_write,
  output logic [31:0]             mem_cmd_address,
  output logic [31:0]             mem_wr_data,
  input  logic                    mem_wr_data_ready,
  input  logic [31:0]             mem_rd_data,
  input  logic                    mem_rd_data_valid,
  output logic [31:0]             fill_address,
  output logic [31:0]             fill_data,
  output logic                    fill_write_enable,
  output logic                    done
);

  // state   | meaning
  // IDLE    | waiting for a miss request
  // WB_CMD  | write-burst command for the dirty victim line
  // WB_DATA | victim words 0..3 handed to memory
  // RD_CMD  | read-burst command for the missing line
  // RD_DATA | returned words captured into the fill port
  // DONE    | last fill strobe, done pulse
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WB_CMD  = 3'd1;
  localparam logic [2:0] ST_WB_DATA = 3'd2;
  localparam logic [2:0] ST_RD_CMD  = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  logic [2:0]              state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [27:0]             line_addr_q, line_addr_d;
  logic [TAG_BITWIDTH-1:0] tag_q, tag_d;
  logic [127:0]            victim_q, victim_d;
  logic                    fill_we_q, fill_we_d;
  logic [31:0]             fill_data_q, fill_data_d;
  logic [31:0]             fill_addr_q, fill_addr_d;

  logic [31:0] line_base;
  logic [31:0] wb_base;

  assign line_base = {line_addr_q, 4'h0};
  assign wb_base   = {tag_q, line_addr_q[LINE_IX_BITWIDTH-1:0], 4'h0};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_addr_d = line_addr_q;
    tag_d       = tag_q;
    victim_d    = victim_q;
    fill_we_d   = 1'b0;
    fill_data_d = fill_data_q;
    fill_addr_d = fill_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          line_addr_d = req_address[31:4];
          tag_d       = req_evict_tag;
          victim_d    = req_evict_line;
          cnt_d       = 2'd0;
          state_d     = req_evict ? ST_WB_CMD : ST_RD_CMD;
        end
      end
      ST_WB_CMD: begin
        if (mem_cmd_ready) begin
          cnt_d   = 2'd0;
          state_d = ST_WB_DATA;
        end
      end
      ST_WB_DATA: begin
        if (mem_wr_data_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_RD_CMD;
        end
      end
      ST_RD_CMD: begin
        if (mem_cmd_ready) begin
          cnt_d   = 2'd0;
          state_d = ST_RD_DATA;
        end
      end
      ST_RD_DATA: begin
        // Word index rides in the address; the strobe lands one cycle after the beat.
        if (mem_rd_data_valid) begin
          fill_we_d   = 1'b1;
          fill_data_d = mem_rd_data;
          fill_addr_d = {line_addr_q, cnt_q, 2'b00};
          cnt_d       = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      line_addr_q <= 28'h0;
      tag_q       <= '0;
      victim_q    <= 128'h0;
      fill_we_q   <= 1'b0;
      fill_data_q <= 32'h0;
      fill_addr_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      line_addr_q <= line_addr_d;
      tag_q       <= tag_d;
      victim_q    <= victim_d;
      fill_we_q   <= fill_we_d;
      fill_data_q <= fill_data_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  always_comb begin
    req_ready       = (state_q == ST_IDLE);
    mem_cmd_valid   = (state_q == ST_WB_CMD) || (state_q == ST_RD_CMD);
    mem_cmd_write   = (state_q == ST_WB_CMD);
    mem_cmd_address = 32'h0;
    mem_wr_data     = 32'h0;
    if (state_q == ST_WB_CMD) mem_cmd_address = wb_base;
    if (state_q == ST_RD_CMD) mem_cmd_address = line_base;
    if (state_q == ST_WB_DATA) mem_wr_data = victim_q[{cnt_q, 5'd0} +: 32];
    fill_address      = fill_addr_q;
    fill_data         = fill_data_q;
    fill_write_enable = fill_we_q;
    done              = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Bench for cache_line_fill_ctrl: a randomized burst-memory responder logs every observable
// event, and each scenario compares that log against the event list expected for the miss.
module tb_cache_line_fill_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid;
  logic         req_ready;
  logic [31:0]  req_address;
  logic         req_evict;
  logic [19:0]  req_evict_tag;
  logic [127:0] req_evict_line;
  logic         mem_cmd_valid;
  logic         mem_cmd_ready;
  logic         mem_cmd_write;
  logic [31:0]  mem_cmd_address;
  logic [31:0]  mem_wr_data;
  logic         mem_wr_data_ready;
  logic [31:0]  mem_rd_data;
  logic         mem_rd_data_valid;
  logic [31:0]  fill_address;
  logic [31:0]  fill_data;
  logic         fill_write_enable;
  logic         done;

  always #5 clk = ~clk;

  cache_line_fill_ctrl #(.LINE_IX_BITWIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_evict(req_evict), .req_evict_tag(req_evict_tag), .req_evict_line(req_evict_line),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_write(mem_cmd_write),
    .mem_cmd_address(mem_cmd_address), .mem_wr_data(mem_wr_data),
    .mem_wr_data_ready(mem_wr_data_ready), .mem_rd_data(mem_rd_data),
    .mem_rd_data_valid(mem_rd_data_valid), .fill_address(fill_address), .fill_data(fill_data),
    .fill_write_enable(fill_write_enable), .done(done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef logic [66:0] ev_t;   // {kind, address, data}
  localparam logic [2:0] EV_WCMD = 3'd0;
  localparam logic [2:0] EV_RCMD = 3'd1;
  localparam logic [2:0] EV_WR   = 3'd2;
  localparam logic [2:0] EV_FILL = 3'd3;
  localparam logic [2:0] EV_DONE = 3'd4;

  ev_t         ev_log[$];
  ev_t         exp_q[$];
  logic [31:0] rd_words[$];

  int p_cmd = 100, p_wr = 100, p_rd = 100, cmd_stall = 0;
  bit spurious = 1'b0;
  int done_cnt = 0, done_bad = 0, stab_err = 0;

  function automatic ev_t mk_ev(input logic [2:0] k, input logic [31:0] a, input logic [31:0] d);
    return {k, a, d};
  endfunction

  function automatic int ev_diff();
    int n = (ev_log.size() > exp_q.size()) ? ev_log.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      ev_t g = (i < ev_log.size()) ? ev_log[i] : 'x;
      ev_t e = (i < exp_q.size()) ? exp_q[i] : 'x;
      if (g !== e) return i;
    end
    return -1;
  endfunction

  function automatic ev_t got_at(input int i);
    return (i >= 0 && i < ev_log.size()) ? ev_log[i] : 'x;
  endfunction

  function automatic ev_t exp_at(input int i);
    return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 'x;
  endfunction

  function automatic int n_fills();
    int n = 0;
    foreach (ev_log[i]) if (ev_log[i][66:64] == EV_FILL) n++;
    return n;
  endfunction

  // Burst-memory responder and observer: samples DUT outputs on the falling edge, then drives.
  initial begin : mem_side
    int wr_left, rd_left, stall_cnt, fills_since_done;
    bit pend;
    logic pend_write;
    logic [31:0] pend_addr;
    wr_left = 0; rd_left = 0; stall_cnt = 0; fills_since_done = 0;
    pend = 1'b0; pend_write = 1'b0; pend_addr = 32'h0;
    mem_cmd_ready = 1'b0; mem_wr_data_ready = 1'b0;
    mem_rd_data = 32'h0; mem_rd_data_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_left = 0; rd_left = 0; stall_cnt = 0; fills_since_done = 0; pend = 1'b0;
        rd_words.delete();
        mem_cmd_ready = 1'b0; mem_wr_data_ready = 1'b0;
        mem_rd_data = 32'h0; mem_rd_data_valid = 1'b0;
      end else begin
        if (fill_write_enable) begin
          ev_log.push_back(mk_ev(EV_FILL, fill_address, fill_data));
          fills_since_done++;
        end
        if (done) begin
          ev_log.push_back(mk_ev(EV_DONE, 32'h0, 32'h0));
          done_cnt++;
          if (!fill_write_enable || fills_since_done != 4) done_bad++;
          fills_since_done = 0;
        end
        mem_wr_data_ready = 1'b0;
        if (wr_left > 0) begin
          if ($urandom_range(99) < p_wr) begin
            mem_wr_data_ready = 1'b1;
            ev_log.push_back(mk_ev(EV_WR, 32'h0, mem_wr_data));
            wr_left--;
          end
        end else if (spurious) mem_wr_data_ready = 1'($urandom_range(1));
        mem_rd_data_valid = 1'b0;
        mem_rd_data = $urandom();
        if (rd_left > 0) begin
          if ($urandom_range(99) < p_rd) begin
            mem_rd_data_valid = 1'b1;
            if (rd_words.size() > 0) mem_rd_data = rd_words.pop_front();
            else mem_rd_data = 32'hBAD0_BAD0;
            rd_left--;
          end
        end else if (spurious) begin
          mem_rd_data_valid = 1'($urandom_range(1));
          mem_rd_data = {16'hDEAD, 16'($urandom())};
        end
        mem_cmd_ready = 1'b0;
        if (mem_cmd_valid) begin
          if (pend && (mem_cmd_write !== pend_write || mem_cmd_address !== pend_addr)) stab_err++;
          if (stall_cnt < cmd_stall) stall_cnt++;
          else if ($urandom_range(99) < p_cmd) mem_cmd_ready = 1'b1;
          if (mem_cmd_ready) begin
            ev_log.push_back(mk_ev(mem_cmd_write ? EV_WCMD : EV_RCMD, mem_cmd_address, 32'h0));
            if (mem_cmd_write) wr_left = 4;
            else rd_left = 4;
            pend = 1'b0;
            stall_cnt = 0;
          end else begin
            pend = 1'b1; pend_write = mem_cmd_write; pend_addr = mem_cmd_address;
          end
        end else begin
          if (pend) stab_err++;
          pend = 1'b0;
          if (spurious) mem_cmd_ready = 1'($urandom_range(1));
        end
      end
    end
  end

  task automatic set_mem(input int pc, input int pw, input int pr, input int st, input bit sp);
    p_cmd = pc; p_wr = pw; p_rd = pr; cmd_stall = st; spurious = sp;
  endtask

  task automatic clear_logs();
    ev_log.delete(); exp_q.delete(); rd_words.delete();
    done_bad = 0; stab_err = 0;
  endtask

  // Reference: what memory and the cache must see for one miss, straight from the address rules.
  task automatic model_txn(input logic [31:0] a, input bit ev, input logic [19:0] tag,
                           input logic [127:0] victim, input logic [127:0] rdline);
    logic [31:0] base;
    base = a & 32'hFFFF_FFF0;
    if (ev) begin
      exp_q.push_back(mk_ev(EV_WCMD, {tag, a[11:4], 4'h0}, 32'h0));
      for (int i = 0; i < 4; i++) exp_q.push_back(mk_ev(EV_WR, 32'h0, victim[32*i +: 32]));
    end
    exp_q.push_back(mk_ev(EV_RCMD, base, 32'h0));
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(mk_ev(EV_FILL, base + 32'(4 * i), rdline[32*i +: 32]));
      rd_words.push_back(rdline[32*i +: 32]);
    end
    exp_q.push_back(mk_ev(EV_DONE, 32'h0, 32'h0));
  endtask

  task automatic issue(input logic [31:0] a, input bit ev, input logic [19:0] tag,
                       input logic [127:0] victim, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_address = a; req_evict = ev;
    req_evict_tag = tag; req_evict_line = victim;
    for (int c = 0; c < 200; c++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(negedge clk);
    req_valid = 1'b0; req_address = $urandom(); req_evict = 1'($urandom_range(1));
    req_evict_tag = 20'($urandom());
    req_evict_line = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk); #1;
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    req_valid = 1'b0; req_address = 32'h0; req_evict = 1'b0;
    req_evict_tag = 20'h0; req_evict_line = 128'h0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_address, mem_wr_data, fill_address, fill_data,
         fill_write_enable, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cmd_v=%b wr=%b addr=%h wdata=%h faddr=%h fdata=%h fwe=%b done=%b, required all 0",
               mem_cmd_valid, mem_cmd_write, mem_cmd_address, mem_wr_data, fill_address,
               fill_data, fill_write_enable, done);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b required 1", req_ready);
    end
    n_checks++;
    if ({mem_cmd_valid, fill_write_enable, done} !== 3'b000) begin
      n_fail++; $display("FAIL post_reset_idle: got cmd_v/fwe/done=%b required 000",
                         {mem_cmd_valid, fill_write_enable, done});
    end
  endtask

  task automatic run_txn(input string name, input logic [31:0] a, input bit ev,
                         input logic [19:0] tag, input logic [127:0] victim,
                         input logic [127:0] rdline);
    bit ok;
    int d;
    clear_logs();
    model_txn(a, ev, tag, victim, rdline);
    issue(a, ev, tag, victim, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s accept: got no accept, required accept", name); end
    wait_done(done_cnt + 1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL %s done_timeout: got no done, required done", name); end
    d = ev_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL %s events: index %0d got %h required %h", name, d, got_at(d), exp_at(d));
    end
    n_checks++;
    if (done_bad != 0 || stab_err != 0) begin
      n_fail++;
      $display("FAIL %s protocol: got done_bad=%0d cmd_unstable=%0d required 0/0", name, done_bad, stab_err);
    end
  endtask

  task automatic test_clean_miss();
    set_mem(100, 100, 100, 0, 1'b0);
    run_txn("clean_miss", 32'h0000_1234, 1'b0, 20'h0, 128'h0,
            {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0});
    n_checks++;
    if (got_at(0) !== mk_ev(EV_RCMD, 32'h0000_1230, 32'h0)) begin
      n_fail++; $display("FAIL clean_miss_rd_cmd: got %h required read cmd at 00001230", got_at(0));
    end
  endtask

  task automatic test_dirty_miss();
    logic [127:0] victim;
    victim = {$urandom(), $urandom(), $urandom(), $urandom()};
    set_mem(100, 100, 100, 0, 1'b0);
    run_txn("dirty_miss", 32'h0005_6234, 1'b1, 20'h00001, victim,
            {$urandom(), $urandom(), $urandom(), $urandom()});
    n_checks++;
    if (got_at(0) !== mk_ev(EV_WCMD, 32'h0000_1230, 32'h0)) begin
      n_fail++; $display("FAIL dirty_miss_wb_cmd: got %h required write cmd at 00001230", got_at(0));
    end
  endtask

  task automatic test_stalls();
    set_mem(100, 50, 40, 5, 1'b0);
    run_txn("stalls", $urandom(), 1'b1, 20'($urandom()),
            {$urandom(), $urandom(), $urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()});
    n_checks++;
    if (n_fills() != 4) begin
      n_fail++; $display("FAIL stalls_fill_count: got %0d required 4", n_fills());
    end
  endtask

  task automatic test_spurious();
    set_mem(70, 70, 70, 0, 1'b1);
    clear_logs();
    repeat (20) @(negedge clk);
    n_checks++;
    if (ev_log.size() != 0) begin
      n_fail++; $display("FAIL spurious_idle: got %0d events while idle required 0", ev_log.size());
    end
    run_txn("spurious", $urandom(), 1'b1, 20'($urandom()),
            {$urandom(), $urandom(), $urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()});
    set_mem(100, 100, 100, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int d, fills_at_reset;
    logic [31:0] a;
    a = $urandom();
    set_mem(100, 100, 100, 0, 1'b0);
    clear_logs();
    model_txn(a, 1'b0, 20'h0, 128'h0, {$urandom(), $urandom(), $urandom(), $urandom()});
    issue(a, 1'b0, 20'h0, 128'h0, ok);
    ok = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk); #1;
      if (n_fills() >= 2) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL reset_mid_wait: got %0d fills required 2", n_fills()); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_cmd_valid, mem_cmd_write, mem_cmd_address, mem_wr_data, fill_address, fill_data,
         fill_write_enable, done} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got cmd_v=%b faddr=%h fdata=%h fwe=%b done=%b required all 0",
               mem_cmd_valid, fill_address, fill_data, fill_write_enable, done);
    end
    fills_at_reset = n_fills();
    repeat (3) @(negedge clk);
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    d = ev_diff();
    n_checks++;
    if (d != -1 || fills_at_reset != 2) begin
      n_fail++;
      $display("FAIL reset_mid_partial: index %0d got %h required %h fills %0d required 2",
               d, got_at(d), exp_at(d), fills_at_reset);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_ready: got %b required 1", req_ready);
    end
    run_txn("after_reset", $urandom(), 1'b1, 20'($urandom()),
            {$urandom(), $urandom(), $urandom(), $urandom()},
            {$urandom(), $urandom(), $urandom(), $urandom()});
  endtask

  task automatic test_back_to_back();
    int accepts, target, d;
    logic [31:0] a;
    a = $urandom();
    set_mem(80, 80, 80, 0, 1'b0);
    clear_logs();
    model_txn(a, 1'b0, 20'h0, 128'h0, {$urandom(), $urandom(), $urandom(), $urandom()});
    model_txn(a, 1'b0, 20'h0, 128'h0, {$urandom(), $urandom(), $urandom(), $urandom()});
    target = done_cnt + 2;
    accepts = 0;
    @(negedge clk);
    req_valid = 1'b1; req_address = a; req_evict = 1'b0;
    req_evict_tag = 20'h0; req_evict_line = 128'h0;
    for (int c = 0; c < 800; c++) begin
      #1;
      if (done_cnt >= target) break;
      if (req_ready) accepts++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (accepts != 2 || done_cnt != target) begin
      n_fail++;
      $display("FAIL back_to_back_accepts: got accepts=%0d done_delta=%0d required 2/2",
               accepts, done_cnt - target + 2);
    end
    d = ev_diff();
    n_checks++;
    if (d != -1) begin
      n_fail++;
      $display("FAIL back_to_back_events: index %0d got %h required %h", d, got_at(d), exp_at(d));
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      set_mem($urandom_range(100, 30), $urandom_range(100, 30), $urandom_range(100, 30),
              $urandom_range(3), 1'($urandom_range(1)));
      run_txn($sformatf("random_%0d", t), $urandom(), 1'($urandom_range(1)), 20'($urandom()),
              {$urandom(), $urandom(), $urandom(), $urandom()},
              {$urandom(), $urandom(), $urandom(), $urandom()});
    end
    set_mem(100, 100, 100, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

endmodule
